// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO: derived widths and
// the elaboration-time legality test for the parameter set.
package fifo_pkg;

    // Pointer width; a natural binary wrap of this width is the modulo-DEPTH wrap.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width, wide enough to hold DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit params_ok(input int data_w, input int depth,
                                     input int af_thresh, input int ae_thresh);
        return (data_w >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh < af_thresh);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read with enable.
// The read register is the FIFO's data output, so it alone carries a reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 64,
    localparam int AW     = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Write port; contents are intentionally left unreset so this maps to block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value whenever no read is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with threshold flags, sticky error flags,
// synchronous flush and write-through-read when full.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 64,
    parameter  int AF_THRESH = 60,
    parameter  int AE_THRESH = 4,
    localparam int AW        = ptr_width(DEPTH),
    localparam int CW        = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] buf_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] buf_out,
    input  logic              flush,
    input  logic              err_clr,
    output logic              buf_empty,
    output logic              buf_full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow,
    output logic [CW-1:0]     fifo_counter
);

    if (!params_ok(DATA_W, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("sync_fifo_param: illegal DATA_W/DEPTH/AF_THRESH/AE_THRESH combination");
    end

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r, count_nxt_s;
    logic          empty_r, full_r, ae_r, af_r, ovf_r, udf_r;
    logic          rd_acc_s, wr_acc_s, ram_we_s, ram_re_s, ovf_set_s, udf_set_s;

    // Accept decisions use the flags registered at the start of the cycle.
    always_comb begin
        rd_acc_s  = rd_en & ~empty_r;
        wr_acc_s  = wr_en & (~full_r | rd_acc_s);
        ram_we_s  = wr_acc_s & ~flush & ~rst;
        ram_re_s  = rd_acc_s & ~flush;
        ovf_set_s = wr_en & ~wr_acc_s & ~flush;
        udf_set_s = rd_en & ~rd_acc_s & ~flush;
        if (flush) begin
            count_nxt_s = CNT_ZERO;
        end else if (wr_acc_s && !rd_acc_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (rd_acc_s && !wr_acc_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointers, occupancy and status flags; flags come from the next count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            ae_r     <= 1'b1;
            af_r     <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_r <= PTR_ZERO;
                rd_ptr_r <= PTR_ZERO;
            end else begin
                if (wr_acc_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
                if (rd_acc_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == CNT_ZERO);
            full_r  <= (count_nxt_s == CNT_FULL);
            ae_r    <= (count_nxt_s <= CNT_AE);
            af_r    <= (count_nxt_s >= CNT_AF);
        end
    end

    // Sticky error flags; a same-cycle clear beats a set.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (ovf_set_s) ovf_r <= 1'b1;
            if (udf_set_s) udf_r <= 1'b1;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we_s),
        .waddr (wr_ptr_r),
        .wdata (buf_in),
        .re    (ram_re_s),
        .raddr (rd_ptr_r),
        .rdata (buf_out)
    );

    assign fifo_counter = count_r;
    assign buf_empty    = empty_r;
    assign buf_full     = full_r;
    assign almost_empty = ae_r;
    assign almost_full  = af_r;
    assign overflow     = ovf_r;
    assign underflow    = udf_r;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised scoreboard bench for sync_fifo_param: a queue-based reference
// model predicts every cycle's outputs, and a negedge monitor compares them.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0, wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, err_clr = 1'b0;
    logic [DW-1:0] buf_in = 8'h00;
    logic [DW-1:0] buf_out;
    logic          buf_empty, buf_full, almost_empty, almost_full, overflow, underflow;
    logic [CW-1:0] fifo_counter;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .buf_in(buf_in), .rd_en(rd_en),
        .buf_out(buf_out), .flush(flush), .err_clr(err_clr),
        .buf_empty(buf_empty), .buf_full(buf_full), .almost_empty(almost_empty),
        .almost_full(almost_full), .overflow(overflow), .underflow(underflow),
        .fifo_counter(fifo_counter)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic e, f, ae, af, ov, un;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] mdl_q[$];
    logic [DW-1:0] mdl_out = 8'h00;
    logic          mdl_ov = 1'b0, mdl_un = 1'b0;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: behaviour stated in terms of a queue and its size.
    task automatic model_step(input logic wr, input logic [DW-1:0] din, input logic rd,
                              input logic fl, input logic ec, input logic rs);
        bit   racc, wacc;
        exp_t x;
        int   n;
        if (rs) begin
            mdl_q.delete();
            mdl_out = 8'h00;
            mdl_ov  = 1'b0;
            mdl_un  = 1'b0;
        end else if (fl) begin
            mdl_q.delete();
            if (ec) begin mdl_ov = 1'b0; mdl_un = 1'b0; end
        end else begin
            racc = rd && (mdl_q.size() != 0);
            wacc = wr && ((mdl_q.size() != DEPTH) || racc);
            if (racc) mdl_out = mdl_q.pop_front();
            if (wacc) mdl_q.push_back(din);
            if (ec) begin
                mdl_ov = 1'b0;
                mdl_un = 1'b0;
            end else begin
                if (wr && !wacc) mdl_ov = 1'b1;
                if (rd && !racc) mdl_un = 1'b1;
            end
        end
        n    = mdl_q.size();
        x.d  = mdl_out;
        x.c  = CW'(n);
        x.e  = (n == 0);
        x.f  = (n == DEPTH);
        x.ae = (n <= AE);
        x.af = (n >= AF);
        x.ov = mdl_ov;
        x.un = mdl_un;
        exp_q.push_back(x);
    endtask

    // Drive one clock cycle of stimulus and record the predicted outcome.
    task automatic cycle(input logic wr, input logic [DW-1:0] din, input logic rd,
                         input logic fl, input logic ec, input logic rs);
        @(negedge clk);
        wr_en = wr; buf_in = din; rd_en = rd; flush = fl; err_clr = ec; rst = rs;
        @(posedge clk);
        model_step(wr, din, rd, fl, ec, rs);
    endtask

    // Monitor: every registered output is checked once per cycle against the model.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_buf_out",      int'(buf_out),      int'(mon_e.d));
            chk("sb_fifo_counter", int'(fifo_counter), int'(mon_e.c));
            chk("sb_buf_empty",    int'(buf_empty),    int'(mon_e.e));
            chk("sb_buf_full",     int'(buf_full),     int'(mon_e.f));
            chk("sb_almost_empty", int'(almost_empty), int'(mon_e.ae));
            chk("sb_almost_full",  int'(almost_full),  int'(mon_e.af));
            chk("sb_overflow",     int'(overflow),     int'(mon_e.ov));
            chk("sb_underflow",    int'(underflow),    int'(mon_e.un));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("rst_counter", int'(fifo_counter), 0);
        chk("rst_empty", int'(buf_empty), 1);
        chk("rst_buf_out", int'(buf_out), 0);

        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            chk("fill_counter", int'(fifo_counter), i);
            chk("fill_almost_empty", int'(almost_empty), (i <= 2) ? 1 : 0);
            chk("fill_almost_full", int'(almost_full), (i >= 14) ? 1 : 0);
        end
        chk("fill_full", int'(buf_full), 1);
        chk("fill_no_overflow", int'(overflow), 0);

        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("full_write_overflow", int'(overflow), 1);
        chk("full_write_counter", int'(fifo_counter), 16);
        cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("full_rw_counter", int'(fifo_counter), 16);
        chk("full_rw_buf_out", int'(buf_out), 8'h01);

        for (int i = 2; i <= 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            chk("drain_buf_out", int'(buf_out), i);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("drain_last_55", int'(buf_out), 8'h55);
        chk("drain_empty", int'(buf_empty), 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("extra_read_underflow", int'(underflow), 1);
        chk("extra_read_hold", int'(buf_out), 8'h55);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("err_clr_overflow", int'(overflow), 0);
        chk("err_clr_underflow", int'(underflow), 0);

        for (int i = 0; i < 3; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            d = DW'($urandom);
            cycle(1'b1, d, ($urandom_range(0, 3) != 0), 1'b0, 1'b0, 1'b0);
            if (fifo_counter >= 5'd4) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            chk("wrap_counter_le4", (fifo_counter <= 5'd4) ? 1 : 0, 1);
        end
        while (fifo_counter != 5'd0) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        cycle(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("empty_rw_counter", int'(fifo_counter), 1);
        chk("empty_rw_underflow", int'(underflow), 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("empty_rw_readback", int'(buf_out), 8'hA5);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) < 55), DW'($urandom), ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 199) == 0));
        end

        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("pre_flush_counter", int'(fifo_counter), 9);
        cycle(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("flush_counter", int'(fifo_counter), 0);
        chk("flush_empty", int'(buf_empty), 1);
        chk("flush_no_overflow", int'(overflow), 0);

        for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), (i > 2), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        chk("mid_rst_counter", int'(fifo_counter), 0);
        chk("mid_rst_buf_out", int'(buf_out), 0);
        chk("mid_rst_flags", int'({buf_empty, buf_full, almost_empty, almost_full, overflow, underflow}),
            6'b101000);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
